// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - one-entry registered RV32 decode stage with load-use interlock
`ifndef DECODE_STAGE_DEFINES
`define DECODE_STAGE_DEFINES
`define ADD       6'd0
`define SUB       6'd1
`define SLL       6'd2
`define SLT       6'd3
`define SLTU      6'd4
`define XOR       6'd5
`define SRL       6'd6
`define SRA       6'd7
`define OR        6'd8
`define AND       6'd9
`define MUL       6'd10
`define BEQ       6'd16
`define BNE       6'd17
`define BLT       6'd18
`define BGE       6'd19
`define BLTU      6'd20
`define BGEU      6'd21
`define JAL       6'd22
`define DEFAULT   6'd63
`define SIZE_BYTE 2'd0
`define SIZE_HWORD 2'd1
`define SIZE_WORD 2'd2
`endif

module decode_stage #(
    parameter int XLEN      = 32,
    parameter int ENABLE_M  = 1,
    parameter int HAZARD_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_wEn,
    output logic [1:0]      out_op_A_sel,
    output logic            out_op_B_sel,
    output logic [5:0]      out_ALU_Control,
    output logic            out_branch_op,
    output logic            out_mem_wEn,
    output logic [1:0]      out_MemSize,
    output logic            out_load_extend_sign,
    output logic            out_wb_sel,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // Whole output register kept as one word so bubbles, flushes and reset share one safe value
    localparam int PW = XLEN + 33;
    localparam logic [PW-1:0] SAFE_WORD = {1'b0, {XLEN{1'b0}}, 15'd0, 1'b1, 2'b00, 1'b0,
                                           `DEFAULT, 1'b0, 1'b1, `SIZE_BYTE, 1'b0, 1'b0, 1'b0};

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd, rs1, rs2;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    logic       d_wEn, d_b, d_br, d_mwEn, d_sign, d_wb, d_ill;
    logic [1:0] d_a, d_size;
    logic [5:0] d_alu;

    // Opcode/funct decode into control fields; illegal encodings collapse to safe controls
    always_comb begin
        d_wEn  = 1'b1;
        d_a    = 2'b00;
        d_b    = 1'b0;
        d_alu  = `DEFAULT;
        d_br   = 1'b0;
        d_mwEn = 1'b1;
        d_size = `SIZE_BYTE;
        d_sign = 1'b0;
        d_wb   = 1'b0;
        d_ill  = 1'b0;
        case (opcode)
            OPC_R: begin
                d_wEn = 1'b0;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  d_alu = `ADD;
                            3'b001:  d_alu = `SLL;
                            3'b010:  d_alu = `SLT;
                            3'b011:  d_alu = `SLTU;
                            3'b100:  d_alu = `XOR;
                            3'b101:  d_alu = `SRL;
                            3'b110:  d_alu = `OR;
                            default: d_alu = `AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000)      d_alu = `SUB;
                        else if (funct3 == 3'b101) d_alu = `SRA;
                        else                       d_ill = 1'b1;
                    end
                    7'b0000001: begin
                        if ((ENABLE_M != 0) && (funct3 == 3'b000)) d_alu = `MUL;
                        else                                       d_ill = 1'b1;
                    end
                    default: d_ill = 1'b1;
                endcase
            end
            OPC_I: begin
                d_wEn = 1'b0;
                d_b   = 1'b1;
                case (funct3)
                    3'b000:  d_alu = `ADD;
                    3'b010:  d_alu = `SLT;
                    3'b011:  d_alu = `SLTU;
                    3'b100:  d_alu = `XOR;
                    3'b110:  d_alu = `OR;
                    3'b111:  d_alu = `AND;
                    3'b001: begin
                        if (funct7 == 7'b0000000) d_alu = `SLL;
                        else                      d_ill = 1'b1;
                    end
                    default: begin
                        if (funct7 == 7'b0000000)      d_alu = `SRL;
                        else if (funct7 == 7'b0100000) d_alu = `SRA;
                        else                           d_ill = 1'b1;
                    end
                endcase
            end
            OPC_LOAD: begin
                d_wEn = 1'b0;
                d_b   = 1'b1;
                d_wb  = 1'b1;
                d_alu = `ADD;
                case (funct3)
                    3'b000:  begin d_size = `SIZE_BYTE;  d_sign = 1'b1; end
                    3'b001:  begin d_size = `SIZE_HWORD; d_sign = 1'b1; end
                    3'b010:  begin d_size = `SIZE_WORD;  d_sign = 1'b1; end
                    3'b100:  d_size = `SIZE_BYTE;
                    3'b101:  d_size = `SIZE_HWORD;
                    default: d_ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                d_mwEn = 1'b0;
                d_b    = 1'b1;
                d_alu  = `ADD;
                case (funct3)
                    3'b000:  d_size = `SIZE_BYTE;
                    3'b001:  d_size = `SIZE_HWORD;
                    3'b010:  d_size = `SIZE_WORD;
                    default: d_ill = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                d_br = 1'b1;
                case (funct3)
                    3'b000:  d_alu = `BEQ;
                    3'b001:  d_alu = `BNE;
                    3'b100:  d_alu = `BLT;
                    3'b101:  d_alu = `BGE;
                    3'b110:  d_alu = `BLTU;
                    3'b111:  d_alu = `BGEU;
                    default: d_ill = 1'b1;
                endcase
            end
            OPC_JAL: begin
                d_wEn = 1'b0;
                d_a   = 2'b10;
                d_alu = `JAL;
            end
            OPC_JALR: begin
                d_wEn = 1'b0;
                d_a   = 2'b10;
                d_b   = 1'b1;
                d_alu = `JAL;
            end
            OPC_AUIPC: begin
                d_wEn = 1'b0;
                d_a   = 2'b01;
                d_b   = 1'b1;
                d_alu = `ADD;
            end
            OPC_LUI: begin
                d_wEn = 1'b0;
                d_a   = 2'b11;
                d_b   = 1'b1;
                d_alu = `ADD;
            end
            default: d_ill = 1'b1;
        endcase
        if (d_ill) begin
            d_wEn  = 1'b1;
            d_a    = 2'b00;
            d_b    = 1'b0;
            d_alu  = `DEFAULT;
            d_br   = 1'b0;
            d_mwEn = 1'b1;
            d_size = `SIZE_BYTE;
            d_sign = 1'b0;
            d_wb   = 1'b0;
        end
    end

    logic use_rs1, use_rs2, stall;

    // Which source registers the incoming opcode actually reads
    always_comb begin
        use_rs1 = (opcode == OPC_R) || (opcode == OPC_I) || (opcode == OPC_LOAD) ||
                  (opcode == OPC_STORE) || (opcode == OPC_BRANCH) || (opcode == OPC_JALR);
        use_rs2 = (opcode == OPC_R) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    end

    // Load in the output register whose rd feeds the incoming instruction; out_rd != 0 keeps x0 out
    assign stall = (HAZARD_EN != 0) && out_valid && out_wb_sel && (out_rd != 5'd0) && in_valid &&
                   ((use_rs1 && (rs1 == out_rd)) || (use_rs2 && (rs2 == out_rd)));

    assign in_ready = (!out_valid || out_ready) && !stall && !flush;

    logic [PW-1:0] out_q, dec_word;
    logic          in_fire, slot_free;

    assign in_fire   = in_valid && in_ready;
    assign slot_free = !out_valid || out_ready;
    assign dec_word  = {1'b1, in_pc, rd, rs1, rs2, d_wEn, d_a, d_b, d_alu, d_br, d_mwEn,
                        d_size, d_sign, d_wb, d_ill};

    assign {out_valid, out_pc, out_rd, out_rs1, out_rs2, out_wEn, out_op_A_sel, out_op_B_sel,
            out_ALU_Control, out_branch_op, out_mem_wEn, out_MemSize, out_load_extend_sign,
            out_wb_sel, out_illegal} = out_q;

    // Output register: flush kills, accepted input loads, a free slot with nothing accepted takes a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= SAFE_WORD;
        end else if (flush) begin
            out_q <= SAFE_WORD;
        end else if (in_fire) begin
            out_q <= dec_word;
        end else if (slot_free) begin
            out_q <= SAFE_WORD;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized model-checked bench for decode_stage
`timescale 1ns/1ps
module tb_decode_stage;

    localparam logic [5:0] A_ADD = 6'd0,  A_SUB = 6'd1,  A_SLL = 6'd2,  A_SLT = 6'd3;
    localparam logic [5:0] A_SLTU = 6'd4, A_XOR = 6'd5,  A_SRL = 6'd6,  A_SRA = 6'd7;
    localparam logic [5:0] A_OR = 6'd8,   A_AND = 6'd9,  A_MUL = 6'd10;
    localparam logic [5:0] A_BEQ = 6'd16, A_BNE = 6'd17, A_BLT = 6'd18, A_BGE = 6'd19;
    localparam logic [5:0] A_BLTU = 6'd20, A_BGEU = 6'd21, A_JAL = 6'd22, A_DEF = 6'd63;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        wen;
        logic [1:0]  a;
        logic        b;
        logic [5:0]  alu;
        logic        br;
        logic        mwen;
        logic [1:0]  size;
        logic        sign;
        logic        wb;
        logic        ill;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, out_ready;
    logic [31:0] in_instr, in_pc;
    logic        rdy [3];
    out_t        obs [3];

    always #5 clk = ~clk;

    // Instance 0: defaults, 1: ENABLE_M=0, 2: HAZARD_EN=0
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic        v, r, wen, b, br, mwen, sign, wb, ill;
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic [1:0]  a, size;
        logic [5:0]  alu;
        decode_stage #(.XLEN(32), .ENABLE_M((g == 1) ? 0 : 1), .HAZARD_EN((g == 2) ? 0 : 1)) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r), .in_instr(in_instr),
            .in_pc(in_pc), .flush(flush), .out_valid(v), .out_ready(out_ready), .out_pc(pc),
            .out_rd(rd), .out_rs1(rs1), .out_rs2(rs2), .out_wEn(wen), .out_op_A_sel(a),
            .out_op_B_sel(b), .out_ALU_Control(alu), .out_branch_op(br), .out_mem_wEn(mwen),
            .out_MemSize(size), .out_load_extend_sign(sign), .out_wb_sel(wb), .out_illegal(ill)
        );
        assign obs[g] = {v, pc, rd, rs1, rs2, wen, a, b, alu, br, mwen, size, sign, wb, ill};
        assign rdy[g] = r;
    end

    int   checks = 0;
    int   failures = 0;
    out_t m [3];
    bit   en_m [3];
    bit   hz [3];
    logic [5:0] r_alu [8];
    logic [5:0] b_alu [8];

    function automatic out_t safe_o();
        out_t o = '0;
        o.wen  = 1'b1;
        o.mwen = 1'b1;
        o.alu  = A_DEF;
        return o;
    endfunction

    // Reference decode from the instruction-set rules
    function automatic out_t dec(logic [31:0] ins, logic [31:0] pc, bit em);
        out_t o = safe_o();
        out_t s;
        bit bad = 0;
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        o.valid = 1'b1; o.pc = pc; o.rd = ins[11:7]; o.rs1 = ins[19:15]; o.rs2 = ins[24:20];
        case (op)
            7'h33: begin
                o.wen = 0;
                if (f7 == 7'h00) o.alu = r_alu[f3];
                else if (f7 == 7'h20 && f3 == 0) o.alu = A_SUB;
                else if (f7 == 7'h20 && f3 == 5) o.alu = A_SRA;
                else if (f7 == 7'h01 && f3 == 0 && em) o.alu = A_MUL;
                else bad = 1;
            end
            7'h13: begin
                o.wen = 0; o.b = 1;
                if (f3 == 1) begin if (f7 == 0) o.alu = A_SLL; else bad = 1; end
                else if (f3 == 5) begin
                    if (f7 == 0) o.alu = A_SRL; else if (f7 == 7'h20) o.alu = A_SRA; else bad = 1;
                end else o.alu = r_alu[f3];
            end
            7'h03: begin
                o.wen = 0; o.b = 1; o.wb = 1; o.alu = A_ADD;
                if (f3 == 3 || f3 == 6 || f3 == 7) bad = 1;
                else begin o.size = f3[1:0]; o.sign = !f3[2]; end
            end
            7'h23: begin
                o.mwen = 0; o.b = 1; o.alu = A_ADD;
                if (f3 > 2) bad = 1; else o.size = f3[1:0];
            end
            7'h63: begin
                o.br = 1;
                if (f3 == 2 || f3 == 3) bad = 1; else o.alu = b_alu[f3];
            end
            7'h6f: begin o.wen = 0; o.a = 2; o.alu = A_JAL; end
            7'h67: begin o.wen = 0; o.a = 2; o.b = 1; o.alu = A_JAL; end
            7'h17: begin o.wen = 0; o.a = 1; o.b = 1; o.alu = A_ADD; end
            7'h37: begin o.wen = 0; o.a = 3; o.b = 1; o.alu = A_ADD; end
            default: bad = 1;
        endcase
        if (bad) begin
            s = safe_o();
            s.valid = 1; s.pc = o.pc; s.rd = o.rd; s.rs1 = o.rs1; s.rs2 = o.rs2; s.ill = 1;
            o = s;
        end
        return o;
    endfunction

    function automatic bit exp_stall(int k);
        logic [6:0] op = in_instr[6:0];
        bit u1 = (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 || op == 7'h63 || op == 7'h67);
        bit u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
        return hz[k] && m[k].valid && m[k].wb && (m[k].rd != 0) && in_valid &&
               ((u1 && in_instr[19:15] == m[k].rd) || (u2 && in_instr[24:20] == m[k].rd));
    endfunction

    function automatic bit exp_rdy(int k);
        return (!m[k].valid || out_ready) && !exp_stall(k) && !flush;
    endfunction

    task automatic set_in(bit iv, logic [31:0] ins, logic [31:0] pc, bit ordy, bit fl);
        in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    endtask

    // Advance one clock edge, updating the reference stage state alongside the DUTs
    task automatic tick();
        out_t nxt [3];
        for (int k = 0; k < 3; k++) begin
            if (flush) nxt[k] = safe_o();
            else if (in_valid && exp_rdy(k)) nxt[k] = dec(in_instr, in_pc, en_m[k]);
            else if (!m[k].valid || out_ready) nxt[k] = safe_o();
            else nxt[k] = m[k];
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) m[k] = nxt[k];
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] op, f7;
        case ($urandom_range(0, 10))
            0, 1:    op = 7'h03;
            2, 3:    op = 7'h33;
            4:       op = 7'h13;
            5:       op = 7'h23;
            6:       op = 7'h63;
            7:       op = ($urandom_range(0, 1) != 0) ? 7'h6f : 7'h67;
            8:       op = ($urandom_range(0, 1) != 0) ? 7'h17 : 7'h37;
            default: op = 7'($urandom);
        endcase
        case ($urandom_range(0, 4))
            0, 1:    f7 = 7'h00;
            2:       f7 = 7'h20;
            3:       f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
                5'($urandom_range(0, 3)), op};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1, 32'h002081B3, 32'hDEAD0000, 1, 0);
        @(negedge clk); @(negedge clk);
        for (int k = 0; k < 3; k++) m[k] = safe_o();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== safe_o()) begin failures++; $display("FAIL reset_out[%0d] got=%h exp=%h", k, obs[k], safe_o()); end
        end
        rst_n = 1'b1;
        set_in(0, 0, 0, 1, 0);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rdy[k] !== 1'b1) begin failures++; $display("FAIL reset_ready[%0d] got=%b exp=1", k, rdy[k]); end
        end
        tick();
    endtask

    task automatic test_add();
        set_in(1, 32'h002081B3, 32'h100, 1, 0);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rdy[k] !== exp_rdy(k)) begin failures++; $display("FAIL add_ready[%0d] got=%b exp=%b", k, rdy[k], exp_rdy(k)); end
        end
        tick();
        checks++;
        if (obs[0].valid !== 1 || obs[0].alu !== A_ADD || obs[0].wen !== 0 || obs[0].rd !== 3 ||
            obs[0].rs1 !== 1 || obs[0].rs2 !== 2 || obs[0].pc !== 32'h100) begin
            failures++; $display("FAIL add_fields got=%h", obs[0]);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== m[k]) begin failures++; $display("FAIL add_out[%0d] got=%h exp=%h", k, obs[k], m[k]); end
        end
    endtask

    task automatic test_load_use();
        set_in(1, 32'h0000A283, 32'h200, 1, 0);
        tick();
        set_in(1, 32'h00228333, 32'h204, 1, 0);
        #1;
        checks++;
        if (rdy[0] !== 0 || rdy[2] !== 1) begin failures++; $display("FAIL lu_stall_ready got=%b%b exp=01", rdy[0], rdy[2]); end
        tick();
        checks++;
        if (obs[0].valid !== 0 || obs[2].valid !== 1 || obs[2].rd !== 6) begin
            failures++; $display("FAIL lu_bubble got0=%h got2=%h", obs[0], obs[2]);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== m[k]) begin failures++; $display("FAIL lu_out[%0d] got=%h exp=%h", k, obs[k], m[k]); end
        end
        tick();
        checks++;
        if (obs[0].valid !== 1 || obs[0].rd !== 6 || obs[0].pc !== 32'h204) begin
            failures++; $display("FAIL lu_issue got=%h", obs[0]);
        end
    endtask

    task automatic test_mul();
        set_in(1, 32'h022081B3, 32'h300, 1, 0);
        tick();
        checks++;
        if (obs[1].ill !== 1 || obs[1].wen !== 1 || obs[1].alu !== A_DEF || obs[1].valid !== 1) begin
            failures++; $display("FAIL mul_off got=%h", obs[1]);
        end
        checks++;
        if (obs[0].ill !== 0 || obs[0].alu !== A_MUL || obs[0].wen !== 0) begin
            failures++; $display("FAIL mul_on got=%h", obs[0]);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== m[k]) begin failures++; $display("FAIL mul_out[%0d] got=%h exp=%h", k, obs[k], m[k]); end
        end
    endtask

    task automatic test_backpressure();
        out_t held;
        set_in(1, 32'h00708393, 32'h400, 1, 0);
        tick();
        held = obs[0];
        set_in(1, 32'h00110113, 32'h404, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (rdy[0] !== 0) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0", c, rdy[0]); end
            checks++;
            if (obs[0] !== held || obs[0] !== m[0]) begin failures++; $display("FAIL bp_hold[%0d] got=%h exp=%h", c, obs[0], held); end
            tick();
        end
        out_ready = 1;
        #1;
        checks++;
        if (rdy[0] !== 1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", rdy[0]); end
        tick();
        checks++;
        if (obs[0].pc !== 32'h404 || obs[0] !== m[0]) begin failures++; $display("FAIL bp_next got=%h exp=%h", obs[0], m[0]); end
    endtask

    task automatic test_flush();
        set_in(1, 32'h00208063, 32'h500, 1, 0);
        tick();
        set_in(1, 32'h00110113, 32'h504, 0, 1);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rdy[k] !== 0) begin failures++; $display("FAIL flush_ready[%0d] got=%b exp=0", k, rdy[k]); end
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== safe_o()) begin failures++; $display("FAIL flush_out[%0d] got=%h exp=%h", k, obs[k], safe_o()); end
        end
        set_in(1, 32'h00110113, 32'h504, 1, 0);
        tick();
        checks++;
        if (obs[0].pc !== 32'h504 || obs[0] !== m[0]) begin failures++; $display("FAIL flush_refetch got=%h exp=%h", obs[0], m[0]); end
    endtask

    task automatic test_async_reset();
        set_in(1, 32'h00308193, 32'h600, 1, 0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== safe_o()) begin failures++; $display("FAIL areset_out[%0d] got=%h exp=%h", k, obs[k], safe_o()); end
            m[k] = safe_o();
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1, 32'h00408213, 32'h700, 1, 0);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rdy[k] !== 1) begin failures++; $display("FAIL areset_ready[%0d] got=%b exp=1", k, rdy[k]); end
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== m[k] || obs[k].pc !== 32'h700) begin failures++; $display("FAIL areset_first[%0d] got=%h exp=%h", k, obs[k], m[k]); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 15) == 0);
            #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== m[k]) begin failures++; $display("FAIL rand_out[%0d] i=%0d got=%h exp=%h", k, i, obs[k], m[k]); end
                checks++;
                if (rdy[k] !== exp_rdy(k)) begin failures++; $display("FAIL rand_ready[%0d] i=%0d got=%b exp=%b", k, i, rdy[k], exp_rdy(k)); end
            end
            tick();
        end
    endtask

    initial begin
        en_m = '{1'b1, 1'b0, 1'b1};
        hz   = '{1'b1, 1'b1, 1'b0};
        r_alu = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
        b_alu = '{A_BEQ, A_BNE, A_DEF, A_DEF, A_BLT, A_BGE, A_BLTU, A_BGEU};
        test_reset();
        test_add();
        test_load_use();
        test_mul();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, the width of the PC path.
REQ-002 The block SHALL have parameter ENABLE_M, default 1; 1 = MUL decoded, 0 = MUL flagged illegal.
REQ-003 The block SHALL have parameter HAZARD_EN, default 1; 1 = load-use interlock active, 0 = interlock disabled.
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1; in_ready  out  1; in_instr  in  32; in_pc  in  XLEN -- fetch-side handshake and payload.
REQ-007 flush  in  1  synchronous kill of the held instruction (taken branch/jump).
REQ-008 out_valid  out  1; out_ready  in  1; out_pc  out  XLEN; out_rd, out_rs1, out_rs2  out  5 each.
REQ-009 Registered controls, all outputs:
- out_wEn  1, register write, active-low
- out_op_A_sel  2
- out_op_B_sel  1
- out_ALU_Control  6
- out_branch_op  1
- out_mem_wEn  1, memory write, active-low
- out_MemSize  2
- out_load_extend_sign  1
- out_wb_sel  1
- out_illegal  1
REQ-010 Control encodings and ALU/MemSize codes SHALL use the existing project `define names (`ADD, `SUB, `MUL, `BEQ ... `JAL, `SIZE_BYTE/HWORD/WORD, `DEFAULT).

Function
REQ-011 Decode SHALL be a one-entry registered pipeline stage: an instruction accepted at edge N appears on out_* after edge N, latency 1 cycle.
REQ-012 A transfer SHALL occur on an edge where in_valid && in_ready; the output is consumed on an edge where out_valid && out_ready.
REQ-013 in_ready SHALL equal (!out_valid || out_ready) && !stall && !flush, combinationally.
REQ-014 While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-015 Per-opcode controls SHALL be as follows:
- R: A=00, B=0, wEn=0, mem_wEn=1, wb_sel=0.
- I-ALU: A=00, B=1.
- LOAD: A=00, B=1, wb_sel=1, ALU=`ADD, plus MemSize and sign from funct3 (000/001/010 signed, 100/101 unsigned).
- STORE: wEn=1, mem_wEn=0, MemSize from funct3.
- BRANCH: branch_op=1, wEn=1, B=0, ALU from funct3.
- JAL/JALR: A=10.
- AUIPC: A=01, B=1, `ADD.
- LUI: A=11, B=1, `ADD.
REQ-016 out_branch_op SHALL be 0 for every non-branch opcode, including AUIPC.
REQ-017 Illegal SHALL be any of:
- an unlisted opcode;
- R funct7 not in {0000000, 0100000, 0000001};
- funct7=0100000 with funct3 other than 000/101;
- funct7=0000001 with funct3≠000;
- SLLI/SRLI/SRAI with bad funct7;
- load funct3 in {011, 110, 111};
- store funct3>010;
- branch funct3 in {010, 011};
- funct7=0000001 with ENABLE_M=0.
REQ-018 An illegal instruction SHALL set out_illegal=1, wEn=1, mem_wEn=1, branch_op=0, ALU=`DEFAULT, and pass through as valid.
REQ-019 rs1 SHALL be used by R, I-ALU, LOAD, STORE, BRANCH and JALR; rs2 by R, STORE and BRANCH; x0 SHALL never match.
REQ-020 stall SHALL be HAZARD_EN && out_valid && out_wb_sel && out_rd≠0 && in_valid && (rs1 used && in rs1==out_rd || rs2 used && in rs2==out_rd).
REQ-021 On stall with out_ready=1, the output register SHALL load a bubble (out_valid=0) and the input SHALL not be accepted; the instruction SHALL be accepted the following cycle.
REQ-022 On stall with out_ready=0, the stage SHALL hold (REQ-014).
REQ-023 flush=1 SHALL clear out_valid at the next edge regardless of out_ready; no input is accepted that edge; flush dominates stall and handshake.
REQ-024 A bubble or flushed slot SHALL present the safe control values of REQ-026 with out_illegal=0.
REQ-025 out_pc SHALL be in_pc latched unmodified, XLEN bits wide; no arithmetic is performed on it.

Reset
REQ-026 While reset=0, independent of clock, every output SHALL take these values:
- out_valid=0
- out_wEn=1, out_mem_wEn=1
- out_branch_op=0, out_illegal=0
- out_op_A_sel=00, out_op_B_sel=0
- out_ALU_Control=`DEFAULT, out_MemSize=`SIZE_BYTE, out_load_extend_sign=0, out_wb_sel=0
- out_pc=0, out_rd=out_rs1=out_rs2=0
REQ-027 An instruction in flight at reset assertion SHALL be discarded, and in_ready SHALL be 1 on the first cycle after reset release.

Verification
REQ-028 add x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle: out_valid=1, ALU=`ADD, wEn=0, rd=3, rs1=1, rs2=2.
REQ-029 lw x5,0(x1) followed by add x6,x5,x2 with HAZARD_EN=1 -> one bubble cycle (out_valid=0, in_ready=0), then the add issues; with HAZARD_EN=0 the add issues with no bubble.
REQ-030 mul x3,x1,x2 (0x022081B3) with ENABLE_M=0 -> out_illegal=1, wEn=1, ALU=`DEFAULT; with ENABLE_M=1 -> ALU=`MUL, out_illegal=0.
REQ-031 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* stable for all 3 cycles; out_ready=1 -> the next instruction is loaded on the following edge.
REQ-032 flush=1 while a beq is held and out_ready=0 -> out_valid=0 next cycle and the fetch instruction is not consumed.
REQ-033 reset pulled low mid-stream, asynchronously between edges -> outputs reach REQ-026 values immediately; after release, in_ready=1 and the first accepted instruction appears 1 cycle later.
